// File: rtl/axi_pkg.sv
// Shared encodings for the cache-to-AXI read arbiter: FSM states, AXI constants
// and the one-bit grant encoding used by the tie-break selector.
package axi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b11
    } state_t;

    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Two-requester selector: fixed priority (data cache wins) or round-robin on ties,
// with the last_grant register that the round-robin policy consults.
module rr_pick
    import axi_pkg::*;
#(
    parameter int ARB_MODE = 0
) (
    input  logic clk,
    input  logic resetn,
    input  logic req_i,
    input  logic req_d,
    input  logic take,
    output logic pick,
    output logic last_grant
);

    always_comb begin
        pick = GNT_I;
        if (req_i && req_d) begin
            pick = (ARB_MODE == 0) ? GNT_D : ~last_grant;
        end else if (req_d) begin
            pick = GNT_D;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= GNT_I;
        end else if (take) begin
            last_grant <= pick;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Merges icache and dcache refill requests onto one AXI read channel with a single
// outstanding transaction; the grant is held from address issue to the rlast beat.
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int          ARB_MODE = 0,
    parameter logic [3:0]  ID_I     = 4'd0,
    parameter logic [3:0]  ID_D     = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] i_araddr,
    input  logic [7:0]  i_arlen,
    input  logic        i_arvalid,
    output logic        i_arready,
    output logic [31:0] i_rdata,
    output logic        i_rlast,
    output logic        i_rvalid,
    input  logic        i_rready,
    input  logic [31:0] d_araddr,
    input  logic [7:0]  d_arlen,
    input  logic        d_arvalid,
    output logic        d_arready,
    output logic [31:0] d_rdata,
    output logic        d_rlast,
    output logic        d_rvalid,
    input  logic        d_rready,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        burst_err,
    output state_t      state,
    output logic [8:0]  beat_cnt
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; the arbiter never makes a valid depend on the matching ready.
    state_t state_next;
    logic   grant;
    logic   pick;
    logic   last_grant;
    logic   take;
    logic   addr_hs;
    logic   beat;
    logic   beat_last;

    assign take      = (state == IDLE) && (i_arvalid || d_arvalid);
    assign addr_hs   = (state == ADDR) && arready;
    assign beat      = (state == DATA) && rvalid && rready;
    assign beat_last = beat && rlast;

    rr_pick #(
        .ARB_MODE(ARB_MODE)
    ) u_pick (
        .clk       (clk),
        .resetn    (resetn),
        .req_i     (i_arvalid),
        .req_d     (d_arvalid),
        .take      (take),
        .pick      (pick),
        .last_grant(last_grant)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (take)      state_next = ADDR;
            ADDR:    if (addr_hs)   state_next = DATA;
            DATA:    if (beat_last) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        arvalid   = 1'b0;
        rready    = 1'b0;
        i_arready = 1'b0;
        d_arready = 1'b0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        i_rlast   = 1'b0;
        d_rlast   = 1'b0;
        case (state)
            ADDR: begin
                arvalid = 1'b1;
                if (grant == GNT_D) d_arready = arready;
                else                i_arready = arready;
            end
            DATA: begin
                if (grant == GNT_D) begin
                    rready   = d_rready;
                    d_rvalid = rvalid;
                    d_rlast  = rlast;
                end else begin
                    rready   = i_rready;
                    i_rvalid = rvalid;
                    i_rlast  = rlast;
                end
            end
            default: ;
        endcase
    end

    assign i_rdata = rdata;
    assign d_rdata = rdata;
    assign arsize  = AXI_SIZE_WORD;
    assign arburst = AXI_BURST_INCR;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant  <= GNT_I;
            arid   <= 4'd0;
            araddr <= 32'd0;
            arlen  <= 8'd0;
        end else if (take) begin
            grant <= pick;
            if (pick == GNT_D) begin
                arid   <= ID_D;
                araddr <= d_araddr;
                arlen  <= d_arlen;
            end else begin
                arid   <= ID_I;
                araddr <= i_araddr;
                arlen  <= i_arlen;
            end
        end else if (beat_last) begin
            grant <= GNT_I;
        end
    end

    // beat_cnt holds beats already accepted, so the rlast beat should see cnt == arlen.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beat_cnt  <= 9'd0;
            burst_err <= 1'b0;
        end else begin
            if (addr_hs) begin
                beat_cnt <= 9'd0;
            end else if (beat && beat_cnt != 9'h1FF) begin
                beat_cnt <= beat_cnt + 9'd1;
            end
            if (beat_last && beat_cnt != {1'b0, arlen}) begin
                burst_err <= 1'b1;
            end else if (beat && !rlast && beat_cnt >= {1'b0, arlen}) begin
                burst_err <= 1'b1;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{rid, rresp, last_grant};

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: a fixed-priority and a round-robin instance share one
// stimulus stream and are compared against a transaction-level model of the rules.
module tb_axi_rd_arbiter;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] i_araddr, d_araddr, rdata;
    logic [7:0]  i_arlen, d_arlen;
    logic        i_arvalid, d_arvalid, i_rready, d_rready;
    logic        arready, rlast, rvalid;
    logic [3:0]  rid;
    logic [1:0]  rresp;

    logic        i_arready_o [2], d_arready_o [2];
    logic [31:0] i_rdata_o [2], d_rdata_o [2], araddr_o [2];
    logic        i_rlast_o [2], d_rlast_o [2], i_rvalid_o [2], d_rvalid_o [2];
    logic [3:0]  arid_o [2];
    logic [7:0]  arlen_o [2];
    logic [2:0]  arsize_o [2];
    logic [1:0]  arburst_o [2];
    logic        arvalid_o [2], rready_o [2], burst_err_o [2];
    logic [1:0]  state_o [2];
    logic [8:0]  beat_cnt_o [2];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        axi_rd_arbiter #(
            .ARB_MODE(k)
        ) u_dut (
            .clk(clk), .resetn(resetn),
            .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid),
            .i_arready(i_arready_o[k]), .i_rdata(i_rdata_o[k]), .i_rlast(i_rlast_o[k]),
            .i_rvalid(i_rvalid_o[k]), .i_rready(i_rready),
            .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arvalid(d_arvalid),
            .d_arready(d_arready_o[k]), .d_rdata(d_rdata_o[k]), .d_rlast(d_rlast_o[k]),
            .d_rvalid(d_rvalid_o[k]), .d_rready(d_rready),
            .arid(arid_o[k]), .araddr(araddr_o[k]), .arlen(arlen_o[k]),
            .arsize(arsize_o[k]), .arburst(arburst_o[k]), .arvalid(arvalid_o[k]),
            .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
            .rlast(rlast), .rvalid(rvalid), .rready(rready_o[k]),
            .burst_err(burst_err_o[k]), .state(state_o[k]), .beat_cnt(beat_cnt_o[k])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per instance, last winner, sticky error and current grant.
    bit          last_g [2];
    bit          err_m [2];
    bit          g [2];
    logic [31:0] ea [2];
    logic [7:0]  el [2];

    function automatic bit winner_is_d(int mode, bit ri, bit rd, bit last_was_d);
        if (ri && rd) return (mode == 0) ? 1'b1 : !last_was_d;
        return rd;
    endfunction

    task automatic chk(input int k, input string tag, input string name,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL dut%0d %s.%s: observed %0h expected %0h", k, tag, name, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk(k, tag, "state", state_o[k], IDLE);
            chk(k, tag, "arvalid", arvalid_o[k], 0);
            chk(k, tag, "rready", rready_o[k], 0);
            chk(k, tag, "rvalid_id", {i_rvalid_o[k], d_rvalid_o[k]}, 0);
        end
    endtask

    task automatic check_reset(input string tag);
        check_idle(tag);
        for (int k = 0; k < 2; k++) begin
            chk(k, tag, "arready_id", {i_arready_o[k], d_arready_o[k]}, 0);
            chk(k, tag, "rlast_id", {i_rlast_o[k], d_rlast_o[k]}, 0);
            chk(k, tag, "arid", arid_o[k], 0);
            chk(k, tag, "araddr", araddr_o[k], 0);
            chk(k, tag, "arlen", arlen_o[k], 0);
            chk(k, tag, "burst_err", burst_err_o[k], 0);
            chk(k, tag, "beat_cnt", beat_cnt_o[k], 0);
        end
    endtask

    task automatic check_addr(input string tag, input bit ar);
        for (int k = 0; k < 2; k++) begin
            chk(k, tag, "state", state_o[k], ADDR);
            chk(k, tag, "arvalid", arvalid_o[k], 1);
            chk(k, tag, "arid", arid_o[k], g[k] ? 4'd1 : 4'd0);
            chk(k, tag, "araddr", araddr_o[k], ea[k]);
            chk(k, tag, "arlen", arlen_o[k], el[k]);
            chk(k, tag, "arsize", arsize_o[k], 3'b010);
            chk(k, tag, "arburst", arburst_o[k], 2'b01);
            chk(k, tag, "i_arready", i_arready_o[k], !g[k] && ar);
            chk(k, tag, "d_arready", d_arready_o[k], g[k] && ar);
            chk(k, tag, "rready", rready_o[k], 0);
        end
    endtask

    task automatic check_data(input string tag, input bit rv, input bit rl, input bit xr,
                              input int cnt);
        for (int k = 0; k < 2; k++) begin
            chk(k, tag, "state", state_o[k], DATA);
            chk(k, tag, "arvalid", arvalid_o[k], 0);
            chk(k, tag, "rready", rready_o[k], xr);
            chk(k, tag, "i_rvalid", i_rvalid_o[k], !g[k] && rv);
            chk(k, tag, "d_rvalid", d_rvalid_o[k], g[k] && rv);
            chk(k, tag, "i_rlast", i_rlast_o[k], !g[k] && rl);
            chk(k, tag, "d_rlast", d_rlast_o[k], g[k] && rl);
            chk(k, tag, "rdata", g[k] ? d_rdata_o[k] : i_rdata_o[k], rdata);
            chk(k, tag, "beat_cnt", beat_cnt_o[k], cnt);
        end
    endtask

    task automatic drive_r(input bit rv, input bit rl, input logic [31:0] d, input bit xr);
        rvalid   = rv;
        rlast    = rl;
        rdata    = d;
        i_rready = xr;
        d_rready = xr;
        rid      = 4'($urandom);
        rresp    = 2'($urandom);
    endtask

    task automatic zero_inputs();
        i_arvalid = 0; d_arvalid = 0; arready = 0;
        i_araddr = 0; d_araddr = 0; i_arlen = 0; d_arlen = 0;
        drive_r(0, 0, 32'd0, 0);
    endtask

    // One transaction from request to return to IDLE; called at a falling edge.
    task automatic run_txn(input string tag, input bit ri, input bit rd,
                           input logic [31:0] ai, input logic [31:0] ad,
                           input logic [7:0] li, input logic [7:0] ld,
                           input int wait_n, input int nbeats, input logic [31:0] dbase,
                           input int bp_beat, input int abort_beat, input bit rnd);
        int  b;
        int  stalls;
        bit  rv, xr;
        i_arvalid = ri; d_arvalid = rd;
        i_araddr = ai; d_araddr = ad; i_arlen = li; d_arlen = ld;
        for (int k = 0; k < 2; k++) begin
            g[k]      = winner_is_d(k, ri, rd, last_g[k]);
            last_g[k] = g[k];
            ea[k]     = g[k] ? ad : ai;
            el[k]     = g[k] ? ld : li;
        end
        #1 check_idle({tag, ".req"});
        @(posedge clk); @(negedge clk);
        for (int w = 0; w <= wait_n; w++) begin
            arready = (w == wait_n);
            #1 check_addr({tag, ".addr"}, arready);
            @(posedge clk); @(negedge clk);
        end
        arready = 0;
        b = 0;
        while (b < nbeats) begin
            stalls = rnd ? int'($urandom_range(0, 2)) : 0;
            if (b == bp_beat) stalls = 3;
            for (int s = 0; s < stalls; s++) begin
                if (b == bp_beat) begin
                    rv = 1; xr = 0;
                end else begin
                    rv = ($urandom_range(0, 1) == 1);
                    xr = !rv && ($urandom_range(0, 1) == 1);
                end
                drive_r(rv, rv && (b == nbeats - 1), dbase + 32'(b), xr);
                #1 check_data({tag, ".stall"}, rv, rv && (b == nbeats - 1), xr, b);
                @(posedge clk); @(negedge clk);
            end
            drive_r(1, b == nbeats - 1, dbase + 32'(b), 1);
            if (b == abort_beat) begin
                resetn = 0;
                #1 check_reset({tag, ".abort"});
                for (int k = 0; k < 2; k++) begin
                    last_g[k] = GNT_I;
                    err_m[k]  = 0;
                end
                @(posedge clk); @(negedge clk);
                zero_inputs();
                resetn = 1;
                return;
            end
            #1 check_data({tag, ".beat"}, 1, b == nbeats - 1, 1, b);
            @(posedge clk); @(negedge clk);
            b++;
        end
        for (int k = 0; k < 2; k++) err_m[k] |= (nbeats != int'(el[k]) + 1);
        zero_inputs();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk(k, {tag, ".end"}, "state", state_o[k], IDLE);
            chk(k, {tag, ".end"}, "burst_err", burst_err_o[k], err_m[k]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  sel;
        bit  ri, rd;
        logic [7:0] li, ld;
        resetn = 0;
        zero_inputs();
        for (int k = 0; k < 2; k++) begin
            last_g[k] = GNT_I;
            err_m[k]  = 0;
        end
        repeat (2) @(negedge clk);
        #1 check_reset("reset");
        resetn = 1;
        @(negedge clk);
        #1 check_idle("idle");

        // A request that vanishes before the edge must not be granted.
        i_arvalid = 1;
        #2 i_arvalid = 0;
        @(posedge clk); @(negedge clk);
        #1 check_idle("drop");

        run_txn("single_i", 1, 0, 32'hBFC0_0000, 32'h0, 8'd7, 8'd0, 1, 8, 32'h1, -1, -1, 0);
        run_txn("tie0", 1, 1, 32'h1000_0000, 32'h2000_0000, 8'd7, 8'd7, 0, 8, 32'h100, -1, -1, 0);
        run_txn("after_d", 1, 0, 32'h1000_0000, 32'h0, 8'd7, 8'd0, 0, 8, 32'h200, -1, -1, 0);
        for (int r = 0; r < 3; r++)
            run_txn("tie_rr", 1, 1, 32'h3000_0000 + 32'(r), 32'h4000_0000 + 32'(r),
                    8'd3, 8'd3, r, 4, 32'h300 + 32'(r * 16), -1, -1, 0);
        run_txn("bp", 0, 1, 32'h0, 32'h5000_0040, 8'd0, 8'd5, 0, 6, 32'hA0, 2, -1, 0);

        for (int t = 0; t < 30; t++) begin
            sel = int'($urandom_range(1, 3));
            ri  = sel[0];
            rd  = sel[1];
            li  = 8'($urandom_range(0, 7));
            ld  = (ri && rd) ? li : 8'($urandom_range(0, 7));
            run_txn("rand", ri, rd, $urandom, $urandom, li, ld,
                    int'($urandom_range(0, 3)), int'(rd ? ld : li) + 1, $urandom, -1, -1, 1);
        end

        run_txn("short", 1, 0, 32'h6000_0000, 32'h0, 8'd7, 8'd0, 0, 4, 32'hC0, -1, -1, 0);
        run_txn("sticky", 0, 1, 32'h0, 32'h7000_0000, 8'd0, 8'd2, 1, 3, 32'hD0, -1, -1, 0);
        run_txn("abort", 0, 1, 32'h0, 32'h8000_0000, 8'd0, 8'd7, 0, 8, 32'hE0, -1, 2, 0);
        run_txn("post_rst", 1, 0, 32'h9000_0000, 32'h0, 8'd3, 8'd0, 0, 4, 32'hF0, -1, -1, 0);
        run_txn("long", 1, 0, 32'hA000_0000, 32'h0, 8'd1, 8'd0, 0, 4, 32'h50, -1, -1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
